// File: rtl/jtag_gpr_access_pkg.sv
// Shared widths, debug op encodings and FSM state type for the JTAG GPR access initiator.
package jtag_gpr_access_pkg;

    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned REG_DATA_WIDTH = 32;

    localparam logic JTAG_OP_READ  = 1'b0;
    localparam logic JTAG_OP_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_VERIFY,
        ST_RESP
    } jtag_state_e;

endpackage

// File: rtl/jtag_gpr_access.sv
// Debug-side initiator for the GPR file JTAG port: one command at a time, write retry on
// core-write collisions, read-back after a successful write, registered outputs throughout.
module jtag_gpr_access
    import jtag_gpr_access_pkg::*;
#(
    parameter int unsigned ADDR_W    = REG_ADDR_WIDTH,
    parameter int unsigned DATA_W    = REG_DATA_WIDTH,
    parameter int unsigned MAX_RETRY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dm_req_valid_i,
    output logic              dm_req_ready_o,
    input  logic              dm_req_op_i,
    input  logic [ADDR_W-1:0] dm_req_addr_i,
    input  logic [DATA_W-1:0] dm_req_data_i,
    output logic              dm_rsp_valid_o,
    input  logic              dm_rsp_ready_i,
    output logic [DATA_W-1:0] dm_rsp_data_o,
    output logic              dm_rsp_err_o,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] core_waddr_i,
    output logic              reg_we_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    input  logic [DATA_W-1:0] reg_rdata_i
);

    localparam int unsigned      CNT_W     = $clog2(MAX_RETRY + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_RETRY);

    jtag_state_e       state_q, state_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  retry_q, retry_d;
    logic [CNT_W-1:0]  retry_next;

    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              reg_we_q, reg_we_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;

    logic collision;

    // Any non-x0 core write wins the register file port, whatever its address.
    assign collision = core_we_i && (core_waddr_i != '0);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
        retry_d    = retry_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        retry_next = (retry_q == CNT_LIMIT) ? retry_q : retry_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (dm_req_valid_i && req_ready_q) begin
                    op_d    = dm_req_op_i;
                    addr_d  = dm_req_addr_i;
                    data_d  = dm_req_data_i;
                    retry_d = '0;
                    if (dm_req_op_i == JTAG_OP_READ) begin
                        state_d = ST_READ;
                    end else if (dm_req_addr_i == '0) begin
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b0;
                        state_d    = ST_RESP;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_READ: begin
                rsp_data_d = reg_rdata_i;
                rsp_err_d  = 1'b0;
                state_d    = ST_RESP;
            end
            ST_WRITE: begin
                if (collision) begin
                    retry_d = retry_next;
                    if (retry_next == CNT_LIMIT) begin
                        rsp_data_d = data_q;
                        rsp_err_d  = (op_q == JTAG_OP_WRITE);
                        state_d    = ST_RESP;
                    end
                end else begin
                    state_d = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                rsp_data_d = reg_rdata_i;
                rsp_err_d  = 1'b0;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_valid_q && dm_rsp_ready_i) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered images of the next state, so they line up with state_q.
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_q == ST_RESP) && (state_d == ST_RESP);
        reg_we_d    = (state_d == ST_WRITE);
        reg_addr_d  = (state_d == ST_IDLE) ? '0 : addr_d;
        reg_wdata_d = (state_d == ST_WRITE) ? data_d : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            retry_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            retry_q     <= retry_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            reg_we_q    <= reg_we_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

    assign dm_req_ready_o = req_ready_q;
    assign dm_rsp_valid_o = rsp_valid_q;
    assign dm_rsp_data_o  = rsp_data_q;
    assign dm_rsp_err_o   = rsp_err_q;
    assign reg_we_o       = reg_we_q;
    assign reg_addr_o     = reg_addr_q;
    assign reg_wdata_o    = reg_wdata_q;

endmodule

// File: tb/tb_jtag_gpr_access.sv
// Scoreboard bench: behavioural register file plus core driver, expected responses predicted
// from a GPR array model at issue time and checked by an independent monitor.
module tb_jtag_gpr_access;

    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXR = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          dm_req_valid_i, dm_req_ready_o, dm_req_op_i;
    logic [AW-1:0] dm_req_addr_i;
    logic [DW-1:0] dm_req_data_i;
    logic          dm_rsp_valid_o, dm_rsp_ready_i, dm_rsp_err_o;
    logic [DW-1:0] dm_rsp_data_o;
    logic          core_we_i;
    logic [AW-1:0] core_waddr_i;
    logic [DW-1:0] core_wdata;
    logic          reg_we_o;
    logic [AW-1:0] reg_addr_o;
    logic [DW-1:0] reg_wdata_o, reg_rdata_i;

    jtag_gpr_access #(.ADDR_W(AW), .DATA_W(DW), .MAX_RETRY(MAXR)) dut (
        .clk(clk), .rst(rst),
        .dm_req_valid_i(dm_req_valid_i), .dm_req_ready_o(dm_req_ready_o),
        .dm_req_op_i(dm_req_op_i), .dm_req_addr_i(dm_req_addr_i), .dm_req_data_i(dm_req_data_i),
        .dm_rsp_valid_o(dm_rsp_valid_o), .dm_rsp_ready_i(dm_rsp_ready_i),
        .dm_rsp_data_o(dm_rsp_data_o), .dm_rsp_err_o(dm_rsp_err_o),
        .core_we_i(core_we_i), .core_waddr_i(core_waddr_i),
        .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
        .reg_rdata_i(reg_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            pulses;
        bit            is_read;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model [32];
    logic [DW-1:0] rf    [32];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            txn_id = 0;
    int            coll_n = 0;
    bit            zero_noise = 1'b0;
    bit            hold_low = 1'b0;
    bit            in_rsp = 1'b0;
    logic [AW-1:0] coll_addr [8];
    logic [DW-1:0] coll_data [8];

    function automatic logic [DW-1:0] preload_val(input int i);
        if (i == 0) return '0;
        if (i == 5) return 32'h1234_5678;
        return DW'(32'h1000_0000 + i * 32'h0101_0101);
    endfunction

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    function automatic logic [AW-1:0] pick_other(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        do r = AW'($urandom_range(1, 31)); while (r == a);
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Register file: core port has priority, combinational read with core-write bypass.
    always_comb begin
        reg_rdata_i = rf[reg_addr_o];
        if (core_we_i && core_waddr_i == reg_addr_o) reg_rdata_i = core_wdata;
        if (reg_addr_o == '0) reg_rdata_i = '0;
    end

    initial begin
        int drv_txn;
        int drv_idx;
        drv_txn = 0;
        drv_idx = 0;
        for (int i = 0; i < 32; i++) rf[i] = preload_val(i);
        core_we_i    = 1'b0;
        core_waddr_i = '0;
        core_wdata   = '0;
        forever begin
            @(posedge clk);
            if (core_we_i && core_waddr_i != '0) rf[core_waddr_i] = core_wdata;
            else if (reg_we_o && reg_addr_o != '0) rf[reg_addr_o] = reg_wdata_o;
            #2;
            if (drv_txn != txn_id) begin
                drv_txn = txn_id;
                drv_idx = 0;
            end
            if (!rst && reg_we_o && drv_idx < coll_n) begin
                core_we_i    = 1'b1;
                core_waddr_i = coll_addr[drv_idx];
                core_wdata   = coll_data[drv_idx];
                drv_idx++;
            end else if (!rst && reg_we_o && zero_noise) begin
                core_we_i    = 1'b1;
                core_waddr_i = '0;
                core_wdata   = $urandom;
            end else begin
                core_we_i    = 1'b0;
                core_waddr_i = AW'($urandom_range(1, 31));
                core_wdata   = $urandom;
            end
        end
    end

    initial begin
        dm_rsp_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            dm_rsp_ready_i = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops an expectation when a response appears, checks it every valid cycle.
    initial begin
        exp_t cur;
        int   pulses;
        int   acc_cyc;
        pulses  = 0;
        acc_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                pulses = 0;
                in_rsp = 1'b0;
                continue;
            end
            if (dm_req_valid_i && dm_req_ready_o) acc_cyc = cyc + 1;
            if (reg_we_o) begin
                pulses++;
                if (exp_q.size() > 0) begin
                    check("we_addr", 64'(reg_addr_o), 64'(exp_q[0].addr));
                    check("we_data", 64'(reg_wdata_o), 64'(exp_q[0].wdata));
                end
            end
            if (dm_rsp_valid_o) begin
                if (!in_rsp) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got valid with data 0x%0h, required no response", dm_rsp_data_o);
                    end else begin
                        cur    = exp_q.pop_front();
                        in_rsp = 1'b1;
                        check("we_pulses", 64'(pulses), 64'(cur.pulses));
                        if (cur.is_read) check("read_latency", 64'(cyc - acc_cyc), 64'd2);
                    end
                end
                if (in_rsp) begin
                    check("rsp_data", 64'(dm_rsp_data_o), 64'(cur.data));
                    check("rsp_err", 64'(dm_rsp_err_o), 64'(cur.err));
                end
                if (dm_rsp_ready_i) begin
                    in_rsp = 1'b0;
                    pulses = 0;
                end
            end
        end
    end

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dm_req_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !in_rsp) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic issue(input bit op, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int n_coll, input logic [AW-1:0] caddr, input bit znoise,
                         input bit aborted);
        exp_t e;
        int   applied;
        wait_idle();
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            coll_addr[i] = (caddr != '0) ? caddr : pick_other(addr);
            coll_data[i] = $urandom;
        end
        coll_n     = n_coll;
        zero_noise = znoise;
        txn_id++;
        e.addr    = addr;
        e.wdata   = wdata;
        e.is_read = (op == 1'b0);
        if (op == 1'b0) begin
            e.data   = model[addr];
            e.err    = 1'b0;
            e.pulses = 0;
        end else if (addr == '0) begin
            e.data   = '0;
            e.err    = 1'b0;
            e.pulses = 0;
        end else begin
            applied = (n_coll < int'(MAXR)) ? n_coll : int'(MAXR);
            if (!aborted) for (int i = 0; i < applied; i++) model[coll_addr[i]] = coll_data[i];
            e.data = wdata;
            if (n_coll >= int'(MAXR)) begin
                e.err    = 1'b1;
                e.pulses = int'(MAXR);
            end else begin
                e.err    = 1'b0;
                e.pulses = n_coll + 1;
                if (!aborted) model[addr] = wdata;
            end
        end
        exp_q.push_back(e);
        dm_req_valid_i = 1'b1;
        dm_req_op_i    = op;
        dm_req_addr_i  = addr;
        dm_req_data_i  = wdata;
        @(posedge clk);
        #1;
        dm_req_valid_i = 1'b0;
        dm_req_op_i    = 1'($urandom);
        dm_req_addr_i  = AW'($urandom);
        dm_req_data_i  = $urandom;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] v;
        bit            got;
        for (int i = 0; i < 32; i++) model[i] = preload_val(i);
        rst            = 1'b1;
        dm_req_valid_i = 1'b0;
        dm_req_op_i    = 1'b0;
        dm_req_addr_i  = '0;
        dm_req_data_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(dm_req_ready_o), 64'd0);
        check("rst_rsp_valid", 64'(dm_rsp_valid_o), 64'd0);
        check("rst_reg_we", 64'(reg_we_o), 64'd0);
        check("rst_reg_addr", 64'(reg_addr_o), 64'd0);
        check("rst_rsp_data", 64'(dm_rsp_data_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        issue(1'b0, 5'd5, '0, 0, '0, 1'b0, 1'b0);
        issue(1'b1, 5'd7, 32'hDEAD_BEEF, 0, '0, 1'b0, 1'b0);
        issue(1'b0, 5'd7, '0, 0, '0, 1'b0, 1'b0);
        issue(1'b1, 5'd7, 32'hA5A5_A5A5, 2, 5'd3, 1'b0, 1'b0);
        issue(1'b0, 5'd7, '0, 0, '0, 1'b0, 1'b0);
        issue(1'b1, 5'd9, 32'h0000_0001, int'(MAXR) + 2, 5'd1, 1'b0, 1'b0);
        issue(1'b0, 5'd9, '0, 0, '0, 1'b0, 1'b0);
        issue(1'b1, 5'd0, 32'h5555_AAAA, 0, '0, 1'b0, 1'b0);
        issue(1'b1, 5'd11, 32'h0BAD_F00D, 0, '0, 1'b1, 1'b0);
        issue(1'b0, 5'd11, '0, 0, '0, 1'b0, 1'b0);
        drain();

        hold_low = 1'b1;
        issue(1'b1, 5'd12, $urandom, 0, '0, 1'b0, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dm_rsp_valid_o) begin
                got = 1'b1;
                break;
            end
        end
        check("hold_rsp_seen", 64'(got), 64'd1);
        repeat (5) @(negedge clk);
        hold_low = 1'b0;
        drain();

        v = ~preload_val(13);
        issue(1'b1, 5'd13, v, 0, '0, 1'b0, 1'b1);
        check("we_before_rst", 64'(reg_we_o), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("abort_req_ready", 64'(dm_req_ready_o), 64'd0);
        check("abort_rsp_valid", 64'(dm_rsp_valid_o), 64'd0);
        check("abort_rsp_data", 64'(dm_rsp_data_o), 64'd0);
        check("abort_rsp_err", 64'(dm_rsp_err_o), 64'd0);
        check("abort_reg_we", 64'(reg_we_o), 64'd0);
        check("abort_reg_addr", 64'(reg_addr_o), 64'd0);
        check("abort_reg_wdata", 64'(reg_wdata_o), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        issue(1'b0, 5'd13, '0, 0, '0, 1'b0, 1'b0);
        drain();

        for (int t = 0; t < 80; t++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
            issue(1'($urandom), a, $urandom, $urandom_range(0, 5), '0, 1'($urandom), 1'b0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
